frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/raster_pkg.sv | 27 ++
 rtl/cycle_watchdog.sv | 34 +++
 rtl/frame_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared definitions for the raster pipeline: sequencer state encoding,
// default frame geometry and small arithmetic helpers.
package raster_pkg;

  localparam int DEFAULT_VERT_RESOLUTION  = 60;
  localparam int DEFAULT_HORIZ_RESOLUTION = 80;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_RENDER    = 3'd2,
    ST_WAIT_SWAP = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_t;

  // Increment that sticks at the top of the 8-bit range.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = 8'hFF;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cycle_watchdog.sv
// Per-frame cycle watchdog: cleared at frame launch, counts while the
// rasterizer is busy, flags expiry when the count reaches LIMIT-1.
module cycle_watchdog #(
  parameter int LIMIT = 16,
  parameter int WIDTH = $clog2(LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Cycle counter; holds at the expiry value so it can never wrap.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST_COUNT)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST_COUNT);

endmodule

// File: rtl/frame_sequencer.sv
// Double-buffered frame sequencer: launches the rasterizer, waits for the
// frame to complete, swaps framebuffer banks on display vsync, counts
// repeated display frames and traps rasterizer hangs with a watchdog.
module frame_sequencer
  import raster_pkg::*;
#(
  parameter int VERT_RESOLUTION  = DEFAULT_VERT_RESOLUTION,
  parameter int HORIZ_RESOLUTION = DEFAULT_HORIZ_RESOLUTION,
  parameter int TIMEOUT_CYCLES   = VERT_RESOLUTION * HORIZ_RESOLUTION + 16
) (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_enable,
  input  logic        i_vsync,
  input  logic        i_raster_done,
  input  logic        i_clear,
  output logic        o_raster_go,
  output logic        o_write_bank,
  output logic        o_read_bank,
  output logic        o_busy,
  output logic        o_fault,
  output logic [15:0] o_frame_count,
  output logic [7:0]  o_missed_count
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t  state_r;
  seq_state_t  next_state_s;
  logic        swap_s;
  logic        miss_s;
  logic        fault_set_s;
  logic        fault_clr_s;
  logic        wd_clear_s;
  logic        wd_enable_s;
  logic        wd_expired_s;

  logic        go_r;
  logic        write_bank_r;
  logic        read_bank_r;
  logic        busy_r;
  logic        fault_r;
  logic [15:0] frame_count_r;
  logic [7:0]  missed_count_r;

  assign wd_clear_s  = (state_r == ST_LAUNCH);
  assign wd_enable_s = (state_r == ST_RENDER);

  cycle_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (WD_WIDTH)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus one-cycle event strobes for the output registers.
  always_comb begin
    next_state_s = state_r;
    swap_s       = 1'b0;
    miss_s       = 1'b0;
    fault_set_s  = 1'b0;
    fault_clr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          next_state_s = ST_LAUNCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        next_state_s = ST_RENDER;
      end
      ST_RENDER: begin
        if (i_raster_done) begin
          // Completion wins over both a coincident vsync and the watchdog.
          if (i_vsync) begin
            swap_s = 1'b1;
            if (i_enable) begin
              next_state_s = ST_LAUNCH;
            end else begin
              next_state_s = ST_IDLE;
            end
          end else begin
            next_state_s = ST_WAIT_SWAP;
          end
        end else begin
          if (i_vsync) begin
            miss_s = 1'b1;
          end else begin
            miss_s = 1'b0;
          end
          if (wd_expired_s) begin
            next_state_s = ST_FAULT;
            fault_set_s  = 1'b1;
          end else begin
            next_state_s = ST_RENDER;
          end
        end
      end
      ST_WAIT_SWAP: begin
        if (i_vsync) begin
          swap_s = 1'b1;
          if (i_enable) begin
            next_state_s = ST_LAUNCH;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_WAIT_SWAP;
        end
      end
      ST_FAULT: begin
        if (i_clear) begin
          next_state_s = ST_IDLE;
          fault_clr_s  = 1'b1;
        end else begin
          next_state_s = ST_FAULT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output registers: the start pulse follows the LAUNCH cycle, busy tracks
  // the RENDER window, banks and counters update on the swap/miss strobes.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      go_r           <= 1'b0;
      write_bank_r   <= 1'b0;
      read_bank_r    <= 1'b1;
      busy_r         <= 1'b0;
      fault_r        <= 1'b0;
      frame_count_r  <= 16'd0;
      missed_count_r <= 8'd0;
    end else begin
      go_r   <= (state_r == ST_LAUNCH);
      busy_r <= (next_state_s == ST_RENDER);

      if (fault_set_s) begin
        fault_r <= 1'b1;
      end else if (fault_clr_s) begin
        fault_r <= 1'b0;
      end else begin
        fault_r <= fault_r;
      end

      if (swap_s) begin
        write_bank_r  <= ~write_bank_r;
        read_bank_r   <= ~read_bank_r;
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        write_bank_r  <= write_bank_r;
        read_bank_r   <= read_bank_r;
        frame_count_r <= frame_count_r;
      end

      if (miss_s) begin
        missed_count_r <= sat_inc8(missed_count_r);
      end else begin
        missed_count_r <= missed_count_r;
      end
    end
  end

  assign o_raster_go    = go_r;
  assign o_write_bank   = write_bank_r;
  assign o_read_bank    = read_bank_r;
  assign o_busy         = busy_r;
  assign o_fault        = fault_r;
  assign o_frame_count  = frame_count_r;
  assign o_missed_count = missed_count_r;

endmodule
